// File: rtl/nios_qsys_pio_sequencer.sv
// -----------------------------------------------------------------------------
// nios_qsys_pio_sequencer
//
// Avalon-MM slave that owns one output line. Software either drives a static
// level on it or programs ON/OFF durations and a pulse count, then starts a
// hardware pulse train. The train is timed cycle-accurately. Completion sets a
// sticky done flag, which can raise a level interrupt.
//
// Register map (word addresses):
//   0 CTRL      write: [0] level, [1] start, [2] stop, [3] irq_en, [5] done clear (W1C)
//               read : [0] level, [3] irq_en, [4] busy, [5] done
//   1 ON_TICKS  R/W, reset 1   (0 behaves as 1)
//   2 OFF_TICKS R/W, reset 1   (0 behaves as 1)
//   3 PULSES    R/W, reset 0   (0 = endless train; reads remaining count while busy)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe (write = chipselect & ~write_n)
//   writedata  write data
//   readdata   combinational read data of the addressed register, unused bits 0
//   out_port   sequenced output line (registered)
//   irq        level interrupt = done & irq_en
// -----------------------------------------------------------------------------
module nios_qsys_pio_sequencer #(
   parameter int unsigned CNT_W       = 16,
   parameter logic        RESET_LEVEL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port,
   output logic        irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // A programmed duration of zero is stretched to one cycle.
   function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] ticks);
      logic [CNT_W-1:0] len;
      if (ticks == CNT_ZERO) begin
         len = CNT_ONE;
      end else begin
         len = ticks;
      end
      return len;
   endfunction

   // State and configuration registers
   logic [1:0]       state_q,     state_d;
   logic             level_q,     level_d;
   logic             irq_en_q,    irq_en_d;
   logic             done_q,      done_d;
   logic             out_q,       out_d;
   logic [CNT_W-1:0] on_ticks_q,  on_ticks_d;
   logic [CNT_W-1:0] off_ticks_q, off_ticks_d;
   logic [CNT_W-1:0] pulses_q,    pulses_d;
   logic [CNT_W-1:0] rem_q,       rem_d;
   logic [CNT_W-1:0] on_cnt_q,    on_cnt_d;
   logic [CNT_W-1:0] off_cnt_q,   off_cnt_d;

   // Decoded bus strobes
   logic             wr_s;
   logic             ctrl_wr_s;
   logic             start_s;
   logic             stop_s;
   logic             busy_s;
   logic             done_set_s;
   logic [CNT_W-1:0] wdata_cnt_s;
   logic             unused_wdata_s;

   assign wr_s        = chipselect & ~write_n;
   assign ctrl_wr_s   = wr_s & (address == 2'd0);
   // Stop dominates start when both arrive in one write.
   assign start_s     = ctrl_wr_s & writedata[1] & ~writedata[2];
   assign stop_s      = ctrl_wr_s & writedata[2];
   assign busy_s      = (state_q != ST_IDLE);
   assign wdata_cnt_s = writedata[CNT_W-1:0];
   // Bits of writedata that no register stores are collected here.
   assign unused_wdata_s = ^writedata;

   // Pulse-train sequencer: next state, phase counters and remaining pulses.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      on_cnt_d   = on_cnt_q;
      off_cnt_d  = off_cnt_q;
      done_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d  = ST_ON;
               rem_d    = pulses_q;
               on_cnt_d = phase_len(on_ticks_q);
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_ON: begin
            if (stop_s) begin
               state_d   = ST_IDLE;
               rem_d     = CNT_ZERO;
               on_cnt_d  = CNT_ZERO;
               off_cnt_d = CNT_ZERO;
            end else if (on_cnt_q <= CNT_ONE) begin
               // Last ON cycle: OFF length is sampled now so a write made
               // during ON applies to this OFF phase.
               state_d   = ST_OFF;
               on_cnt_d  = CNT_ZERO;
               off_cnt_d = phase_len(off_ticks_q);
            end else begin
               on_cnt_d  = on_cnt_q - CNT_ONE;
            end
         end
         ST_OFF: begin
            if (stop_s) begin
               state_d   = ST_IDLE;
               rem_d     = CNT_ZERO;
               on_cnt_d  = CNT_ZERO;
               off_cnt_d = CNT_ZERO;
            end else if (off_cnt_q <= CNT_ONE) begin
               off_cnt_d = CNT_ZERO;
               // PULSES cannot change while busy, so it still tells us
               // whether this train was started in endless mode.
               if (pulses_q == CNT_ZERO) begin
                  state_d  = ST_ON;
                  on_cnt_d = phase_len(on_ticks_q);
               end else if (rem_q <= CNT_ONE) begin
                  state_d    = ST_IDLE;
                  rem_d      = CNT_ZERO;
                  done_set_s = 1'b1;
               end else begin
                  state_d  = ST_ON;
                  rem_d    = rem_q - CNT_ONE;
                  on_cnt_d = phase_len(on_ticks_q);
               end
            end else begin
               off_cnt_d = off_cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rem_d     = CNT_ZERO;
            on_cnt_d  = CNT_ZERO;
            off_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Software-visible register updates from bus writes.
   always_comb begin
      level_d     = level_q;
      irq_en_d    = irq_en_q;
      on_ticks_d  = on_ticks_q;
      off_ticks_d = off_ticks_q;
      pulses_d    = pulses_q;
      if (wr_s) begin
         case (address)
            2'd0: begin
               level_d  = writedata[0];
               irq_en_d = writedata[3];
            end
            2'd1: begin
               on_ticks_d = wdata_cnt_s;
            end
            2'd2: begin
               off_ticks_d = wdata_cnt_s;
            end
            2'd3: begin
               // The running train owns the pulse count.
               if (busy_s) begin
                  pulses_d = pulses_q;
               end else begin
                  pulses_d = wdata_cnt_s;
               end
            end
            default: begin
               level_d = level_q;
            end
         endcase
      end else begin
         level_d = level_q;
      end
   end

   // Sticky done flag: completion in the same cycle as a clear keeps it set.
   always_comb begin
      if (done_set_s) begin
         done_d = 1'b1;
      end else if (ctrl_wr_s && writedata[5]) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end
   end

   // Output line follows the state being entered, so it is registered.
   always_comb begin
      case (state_d)
         ST_ON:   out_d = 1'b1;
         ST_OFF:  out_d = 1'b0;
         ST_IDLE: out_d = level_d;
         default: out_d = level_d;
      endcase
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         level_q     <= RESET_LEVEL;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         out_q       <= RESET_LEVEL;
         on_ticks_q  <= CNT_ONE;
         off_ticks_q <= CNT_ONE;
         pulses_q    <= CNT_ZERO;
         rem_q       <= CNT_ZERO;
         on_cnt_q    <= CNT_ZERO;
         off_cnt_q   <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         out_q       <= out_d;
         on_ticks_q  <= on_ticks_d;
         off_ticks_q <= off_ticks_d;
         pulses_q    <= pulses_d;
         rem_q       <= rem_d;
         on_cnt_q    <= on_cnt_d;
         off_cnt_q   <= off_cnt_d;
      end
   end

   // Read-data multiplexer.
   always_comb begin
      readdata = 32'h0000_0000;
      case (address)
         2'd0: begin
            readdata[0] = level_q;
            readdata[3] = irq_en_q;
            readdata[4] = busy_s;
            readdata[5] = done_q;
         end
         2'd1: begin
            readdata[CNT_W-1:0] = on_ticks_q;
         end
         2'd2: begin
            readdata[CNT_W-1:0] = off_ticks_q;
         end
         2'd3: begin
            if (busy_s) begin
               readdata[CNT_W-1:0] = rem_q;
            end else begin
               readdata[CNT_W-1:0] = pulses_q;
            end
         end
         default: begin
            readdata = 32'h0000_0000;
         end
      endcase
   end

   assign out_port = out_q;
   assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_nios_qsys_pio_sequencer.sv
module tb_nios_qsys_pio_sequencer;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'h0;
   logic [31:0] readdata;
   logic        out_port;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   nios_qsys_pio_sequencer #(.CNT_W(16), .RESET_LEVEL(1'b1)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port), .irq(irq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // A started train is expanded into the list of output levels it must
   // produce, one entry per cycle, with the remaining-pulse count alongside.
   bit          m_level, m_irq_en, m_done, m_inf;
   logic [15:0] m_on, m_off, m_pulses;
   bit          pat_q[$];
   int          rem_q[$];

   task automatic model_reset();
      m_level = 1'b1; m_irq_en = 1'b0; m_done = 1'b0; m_inf = 1'b0;
      m_on = 16'd1; m_off = 16'd1; m_pulses = 16'd0;
      pat_q.delete(); rem_q.delete();
   endtask

   task automatic append_period(int r);
      int on_n, off_n;
      on_n  = (m_on  == 16'd0) ? 1 : int'(m_on);
      off_n = (m_off == 16'd0) ? 1 : int'(m_off);
      for (int i = 0; i < on_n; i++)  begin pat_q.push_back(1'b1); rem_q.push_back(r); end
      for (int i = 0; i < off_n; i++) begin pat_q.push_back(1'b0); rem_q.push_back(r); end
   endtask

   task automatic model_update(logic [1:0] a, logic wr, logic [31:0] wd);
      bit busy_b;
      busy_b = (pat_q.size() != 0);
      if (wr) begin
         case (a)
            2'd0: begin m_level = wd[0]; m_irq_en = wd[3]; if (wd[5]) m_done = 1'b0; end
            2'd1: m_on  = wd[15:0];
            2'd2: m_off = wd[15:0];
            default: if (!busy_b) m_pulses = wd[15:0];
         endcase
      end
      if (busy_b) begin
         if (wr && a == 2'd0 && wd[2]) begin
            pat_q.delete(); rem_q.delete();
         end else begin
            void'(pat_q.pop_front()); void'(rem_q.pop_front());
            if (pat_q.size() == 0) begin
               if (m_inf) append_period(0);
               else m_done = 1'b1;
            end
         end
      end else if (wr && a == 2'd0 && wd[1] && !wd[2]) begin
         m_inf = (m_pulses == 16'd0);
         if (m_inf) append_period(0);
         else for (int k = 0; k < int'(m_pulses); k++) append_period(int'(m_pulses) - k);
      end
   endtask

   function automatic bit exp_out();
      if (pat_q.size() != 0) return pat_q[0];
      return m_level;
   endfunction

   function automatic logic [31:0] exp_rd(logic [1:0] a);
      logic [31:0] r;
      bit busy;
      busy = (pat_q.size() != 0);
      case (a)
         2'd0:    r = {26'd0, m_done, busy, m_irq_en, 2'b00, m_level};
         2'd1:    r = {16'd0, m_on};
         2'd2:    r = {16'd0, m_off};
         default: r = busy ? rem_q[0] : {16'd0, m_pulses};
      endcase
      return r;
   endfunction

   task automatic check32(string name, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
      end
   endtask

   // Model advances on every active edge outside reset.
   initial forever begin
      @(posedge clk);
      if (!reset) model_update(address, chipselect & ~write_n, writedata);
   end

   // Compare process: every cycle, on the inactive edge.
   initial forever begin
      @(negedge clk);
      check32("cyc_out_port", {31'd0, out_port}, {31'd0, exp_out()});
      check32("cyc_irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
      check32("cyc_readdata", readdata, exp_rd(address));
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(logic [1:0] a, logic [31:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic sel(logic [1:0] a);
      @(posedge clk); #1;
      address = a;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      logic [10:0] seq;
      int busy_n, ones, rises;
      bit prev;

      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset asserted mid-cycle takes effect with no clock edge.
      wr(2'd0, 32'h0000_0008);
      idle(2);
      @(posedge clk); #2;
      reset = 1'b1; model_reset();
      #1;
      check32("rst_out_port", {31'd0, out_port}, 32'd1);
      check32("rst_ctrl", readdata, 32'h0000_0001);
      check32("rst_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Finite train: ON=3, OFF=2, two pulses, irq enabled.
      wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd3, 32'd2);
      wr(2'd0, 32'h0000_000A);
      seq = 11'd0; busy_n = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         seq = {seq[9:0], out_port};
         if (readdata[4]) busy_n++;
      end
      check32("finite_pattern", {21'd0, seq}, {21'd0, 11'b11100111000});
      check32("finite_busy_cycles", busy_n, 32'd10);
      check32("finite_done_ctrl", readdata, 32'h0000_0028);
      check32("finite_irq", {31'd0, irq}, 32'd1);
      wr(2'd0, 32'h0000_0028);
      @(negedge clk);
      check32("irq_after_clear", {31'd0, irq}, 32'd0);
      check32("ctrl_after_clear", readdata, 32'h0000_0008);

      // Zero durations behave as one cycle each; idle level is 1.
      wr(2'd1, 32'd0); wr(2'd2, 32'd0); wr(2'd3, 32'd3);
      wr(2'd0, 32'h0000_0003);
      seq = 11'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         seq = {seq[9:0], out_port};
      end
      check32("zero_pattern", {21'd0, seq}, {25'd0, 7'b1010101});
      check32("zero_done_ctrl", readdata, 32'h0000_0021);

      // Endless train, period 8, then stop.
      wr(2'd1, 32'd4); wr(2'd2, 32'd4); wr(2'd3, 32'd0);
      wr(2'd0, 32'h0000_0023);
      ones = 0; rises = 0; prev = 1'b1;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (out_port) ones++;
         if (out_port && !prev) rises++;
         prev = out_port;
      end
      check32("inf_ones", ones, 32'd24);
      check32("inf_rises", rises, 32'd5);
      wr(2'd0, 32'h0000_0004);
      @(negedge clk);
      check32("stop_ctrl", readdata, 32'h0000_0000);
      check32("stop_out_port", {31'd0, out_port}, 32'd0);
      idle(10);

      // Start and stop in one write: nothing starts.
      wr(2'd0, 32'h0000_0006);
      @(negedge clk);
      check32("startstop_ctrl", readdata, 32'h0000_0000);
      idle(3);

      // Start while busy is ignored.
      wr(2'd1, 32'd2); wr(2'd2, 32'd2); wr(2'd3, 32'd2);
      wr(2'd0, 32'h0000_0022);
      wr(2'd0, 32'h0000_0002);
      seq = 11'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         seq = {seq[9:0], out_port};
      end
      check32("restart_pattern", {21'd0, seq}, {25'd0, 7'b0011000});
      check32("restart_done_ctrl", readdata, 32'h0000_0020);

      // PULSES write while busy is ignored; readback shows remaining.
      wr(2'd1, 32'd3); wr(2'd2, 32'd3); wr(2'd3, 32'd5);
      wr(2'd0, 32'h0000_0022);
      wr(2'd3, 32'd9);
      @(negedge clk);
      check32("busy_pulses_read", readdata, 32'd5);
      wr(2'd0, 32'h0000_0004);
      sel(2'd3);
      @(negedge clk);
      check32("idle_pulses_read", readdata, 32'd5);

      // Reset during ON.
      wr(2'd1, 32'd3); wr(2'd2, 32'd3); wr(2'd3, 32'd4);
      wr(2'd0, 32'h0000_0022);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1; model_reset();
      @(negedge clk);
      check32("midrst_out_port", {31'd0, out_port}, 32'd1);
      check32("midrst_ctrl", readdata, 32'h0000_0001);
      @(posedge clk); #1 reset = 1'b0;
      sel(2'd1);
      @(negedge clk);
      check32("midrst_on_ticks", readdata, 32'd1);
      sel(2'd2);
      @(negedge clk);
      check32("midrst_off_ticks", readdata, 32'd1);
      sel(2'd3);
      @(negedge clk);
      check32("midrst_pulses", readdata, 32'd0);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
